// File: rtl/ysyx_22040895_if_id.sv
// IF/ID stage register: two-entry skid buffer between IFU and IDU.
// It also keeps a delivered-beat counter and a saturating downstream-stall counter.
module ysyx_22040895_if_id #(
  parameter int INST_W      = 32,
  parameter int ADDR_W      = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i_ifid,
  output logic                   in_ready_o_ifid,
  input  logic [INST_W-1:0]      in_inst_i_ifid,
  input  logic [ADDR_W-1:0]      in_pc_i_ifid,
  input  logic                   flush_i_ifid,
  output logic                   out_valid_o_ifid,
  input  logic                   out_ready_i_ifid,
  output logic [INST_W-1:0]      out_inst_o_ifid,
  output logic [ADDR_W-1:0]      out_pc_o_ifid,
  output logic [63:0]            inst_cnt_o_ifid,
  output logic [STALL_CNT_W-1:0] stall_cnt_o_ifid
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [INST_W-1:0]      mainInst_q, mainInst_d, skidInst_q, skidInst_d;
  logic [ADDR_W-1:0]      mainPc_q, mainPc_d, skidPc_q, skidPc_d;
  logic [63:0]            instCnt_q, instCnt_d;
  logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic                   push, pop;

  // Handshake flags come from registered state only, so ready never sees out_ready.
  assign out_valid_o_ifid = (state_q != EMPTY);
  assign in_ready_o_ifid  = (state_q != FULL);
  assign push             = in_valid_i_ifid & in_ready_o_ifid;
  assign pop              = out_valid_o_ifid & out_ready_i_ifid;

  assign out_inst_o_ifid  = mainInst_q;
  assign out_pc_o_ifid    = mainPc_q;
  assign inst_cnt_o_ifid  = instCnt_q;
  assign stall_cnt_o_ifid = stallCnt_q;

  always_comb begin
    state_d    = state_q;
    mainInst_d = mainInst_q;
    mainPc_d   = mainPc_q;
    skidInst_d = skidInst_q;
    skidPc_d   = skidPc_q;
    instCnt_d  = instCnt_q + (pop ? 64'd1 : 64'd0);
    stallCnt_d = stallCnt_q;
    if (out_valid_o_ifid && !out_ready_i_ifid && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + STALL_CNT_W'(1);
    end

    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d    = ONE;
          mainInst_d = in_inst_i_ifid;
          mainPc_d   = in_pc_i_ifid;
        end
      end
      ONE: begin
        if (push && pop) begin
          mainInst_d = in_inst_i_ifid;
          mainPc_d   = in_pc_i_ifid;
        end else if (push) begin
          state_d    = FULL;
          skidInst_d = in_inst_i_ifid;
          skidPc_d   = in_pc_i_ifid;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d    = ONE;
          mainInst_d = skidInst_q;
          mainPc_d   = skidPc_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A redirect drops everything held and the incoming beat; data registers may keep stale values.
    if (flush_i_ifid) begin
      state_d    = EMPTY;
      mainInst_d = mainInst_q;
      mainPc_d   = mainPc_q;
      skidInst_d = skidInst_q;
      skidPc_d   = skidPc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      mainInst_q <= '0;
      mainPc_q   <= '0;
      skidInst_q <= '0;
      skidPc_q   <= '0;
      instCnt_q  <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mainInst_q <= mainInst_d;
      mainPc_q   <= mainPc_d;
      skidInst_q <= skidInst_d;
      skidPc_q   <= skidPc_d;
      instCnt_q  <= instCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

// File: doc/ysyx_22040895_if_id.md
Name: ysyx_22040895_if_id

Overview:
- IF/ID stage register between the instruction fetch unit and the decode unit.
- Accepts {inst, pc} beats from IFU over a valid/ready handshake and presents them to the decoder over a second valid/ready handshake.
- Two-entry skid buffer (main + skid) so upstream ready never depends combinationally on downstream ready.
- Supports a flush from the branch/jump redirect (pcsel) path, and keeps two performance counters for DPI-C/difftest inspection.

Parameters:
- INST_W, 32, instruction width (matches ysyx_22040895_InstBus).
- ADDR_W, 64, PC width (matches ysyx_22040895_InstAddrBus).
- STALL_CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid_i_ifid  in  1  IFU beat valid.
- in_ready_o_ifid  out  1  stage can accept a beat this cycle.
- in_inst_i_ifid  in  INST_W  fetched instruction.
- in_pc_i_ifid  in  ADDR_W  PC of the fetched instruction.
- flush_i_ifid  in  1  redirect; discard all held and incoming beats.
- out_valid_o_ifid  out  1  beat available to IDU.
- out_ready_i_ifid  in  1  IDU accepts the beat.
- out_inst_o_ifid  out  INST_W  instruction to IDU.
- out_pc_o_ifid  out  ADDR_W  PC to IDU.
- inst_cnt_o_ifid  out  64  count of beats delivered to IDU.
- stall_cnt_o_ifid  out  STALL_CNT_W  count of downstream-stall cycles.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous, active-high, on rst, and has priority over everything including flush.
  - Reset values: state EMPTY, out_valid=0, out_inst=0, out_pc=0, skid regs=0, inst_cnt=0, stall_cnt=0, in_ready=1 from the first cycle after reset.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid.
  - FULL: main valid, skid valid.
- Outputs vs state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - Both are decoded from registered state only; there is no combinational path from out_ready or in_valid to either.
- Transitions (no flush):
  - EMPTY: push -> ONE, main<=in.
  - ONE:
    - push&pop -> ONE, main<=in.
    - push&!pop -> FULL, skid<=in.
    - !push&pop -> EMPTY.
    - neither -> hold.
  - FULL: push is impossible. pop -> ONE, main<=skid. !pop -> hold.
- Latency: a beat pushed into EMPTY appears on out_* the next cycle (1-cycle latency).
- Throughput: one beat per cycle in steady state when out_ready=1.
- Stability: while out_valid & !out_ready, out_inst/out_pc hold unchanged.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Flush:
  - When flush=1, the next state is EMPTY regardless of push/pop; main and skid are invalidated.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle counts as completed, and inst_cnt increments.
  - out_inst/out_pc data registers are not required to clear; only the valid state clears.
  - in_ready is 1 the cycle after flush.
- Counters:
  - inst_cnt increments by 1 on every pop and wraps modulo 2^64.
  - stall_cnt increments on every cycle with out_valid & !out_ready and saturates at all-ones.
  - Neither counter is cleared by flush.
- Width rules: data paths are pure copies; no sign or zero extension.

Test Plan:
- Streaming: after reset, present pc=0x80000000, 0x80000004, 0x80000008 with insts 0x00000413, 0x00100093, 0x00100073, out_ready=1 -> out_valid rises 1 cycle after the first push; beats appear in order on consecutive cycles; inst_cnt=3; stall_cnt=0.
- Backpressure: out_ready=0, push pc 0x80000000 then 0x80000004 -> state FULL; in_ready=0 on the cycle after the second push; out_pc holds 0x80000000. Raise out_ready -> 0x80000000 then 0x80000004 delivered; in_ready returns to 1; stall_cnt equals the number of held cycles.
- Flush while FULL: buffer holds two beats, flush=1 with in_valid=1 pc=0x8000000c -> next cycle out_valid=0, in_ready=1; pc 0x8000000c is never output; inst_cnt is unchanged.
- Flush coincident with pop: state ONE, out_ready=1, flush=1 -> inst_cnt +1; state EMPTY the next cycle.
- Reset mid-operation: state FULL, rst=1 for one cycle together with flush=1 and in_valid=1 -> all outputs return to reset values; counters read 0.
- Stall saturation (STALL_CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 0xF.
